sr_reg_bank: RTL and testbench

- Parametrised, clocked successor to the single-bit SR latch: WIDTH independent SR storage channels in one synchronous register bank.
- Conflict (S=R=1) handling is selectable by parameter: reset-dominant, set-dominant, toggle, or hold.
- Per-channel conflict pulses, a saturating conflict-cycle counter and a sticky error flag are added for status/debug.
- Used wherever the design needs glitch-free, deterministic set/reset flags instead of an asynchronous latch.

---
 rtl/sr_reg_bank_if.sv | 27 ++
 rtl/sr_reg_bank.sv | 101 ++++++++++
 tb/tb_sr_reg_bank.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_reg_bank_if.sv
// sr_reg_bank_if: request/status bundle for the synchronous SR register bank.
// Latency: none, this is a wiring-only bundle.
// Backpressure: none; master drives en/S/R/clr_err, slave returns state and status.
interface sr_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             clr_err;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic [WIDTH-1:0] conflict;
    logic [CNT_W-1:0] conflict_cnt;
    logic             err_sticky;

    modport master (
        output en, S, R, clr_err,
        input  Q, Qn, conflict, conflict_cnt, err_sticky
    );

    modport slave (
        input  en, S, R, clr_err,
        output Q, Qn, conflict, conflict_cnt, err_sticky
    );
endinterface

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: WIDTH independent clocked SR flags, MODE-selected S=R=1 resolution, conflict status.
// Latency: 1 cycle S/R -> Q; 2 cycles when SR_GLITCH_FILTER_EN is defined (two-edge request filter).
// Backpressure: none; en gates Q/status updates, clr_err clears status even while en is low.
module sr_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    sr_reg_bank_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_conflict;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [WIDTH-1:0] w_s_f;
    logic [WIDTH-1:0] w_r_f;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_any;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_nxt;

`ifdef SR_GLITCH_FILTER_EN
    logic [WIDTH-1:0] r_s_d;
    logic [WIDTH-1:0] r_r_d;

    // One-cycle request history, sampled every cycle independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d <= '0;
            r_r_d <= '0;
        end else begin
            r_s_d <= bus.S;
            r_r_d <= bus.R;
        end
    end

    // A request acts only once it has been high on two consecutive edges.
    assign w_s_f = bus.S & r_s_d;
    assign w_r_f = bus.R & r_r_d;
`else
    assign w_s_f = bus.S;
    assign w_r_f = bus.R;
`endif

    assign w_both = w_s_f & w_r_f;

    // Value a channel takes when both set and reset are requested; unknown MODE values hold.
    always_comb begin
        w_res = r_q;
        case (MODE)
            0:       w_res = '0;
            1:       w_res = '1;
            2:       w_res = ~r_q;
            default: w_res = r_q;
        endcase
    end

    // Per-channel next state: hold when idle, set-only / reset-only win outright, conflict by MODE.
    assign w_q_nxt = (r_q & ~(w_s_f | w_r_f)) | (w_s_f & ~w_r_f) | (w_both & w_res);

    // Status: the clear lands first, then this cycle's conflict is counted on top of it.
    assign w_any      = bus.en & (|w_both);
    assign w_cnt_base = bus.clr_err ? '0 : r_cnt;
    assign w_cnt_nxt  = (w_any && (w_cnt_base != CNT_MAX)) ? (w_cnt_base + CNT_ONE) : w_cnt_base;
    assign w_err_nxt  = (bus.clr_err ? 1'b0 : r_err) | w_any;

    // Channel state and status registers; rst overrides en and clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= RESET_VAL;
            r_conflict <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (bus.en) begin
                r_q <= w_q_nxt;
            end
            r_conflict <= bus.en ? w_both : '0;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.Q            = r_q;
    assign bus.Qn           = ~r_q;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_cnt = r_cnt;
    assign bus.err_sticky   = r_err;

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank: five banks (MODE 0,1,2,3 and out-of-range 5) driven in lockstep.
// Latency: expected state is queued at drive time and popped one edge later.
// Backpressure: none; the bench owns every input.
module tb_sr_reg_bank;

    localparam int         W  = 4;
    localparam int         CW = 2;
    localparam logic [3:0] RV = 4'b1010;

    typedef struct packed {
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        logic [3:0] conf;
        logic [1:0] cnt;
        logic       st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    logic [3:0] m_q0, m_q1, m_q2, m_q3, m_conf, m_sd, m_rd;
    logic [1:0] m_cnt;
    logic       m_st;

    always #5 clk = ~clk;

    sr_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) b0 ();
    sr_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) b1 ();
    sr_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) b2 ();
    sr_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) b3 ();
    sr_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) b4 ();

    sr_reg_bank #(.WIDTH(W), .MODE(0), .CNT_W(CW), .RESET_VAL(RV)) u0 (.clk(clk), .rst(rst), .bus(b0));
    sr_reg_bank #(.WIDTH(W), .MODE(1), .CNT_W(CW), .RESET_VAL(RV)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sr_reg_bank #(.WIDTH(W), .MODE(2), .CNT_W(CW), .RESET_VAL(RV)) u2 (.clk(clk), .rst(rst), .bus(b2));
    sr_reg_bank #(.WIDTH(W), .MODE(3), .CNT_W(CW), .RESET_VAL(RV)) u3 (.clk(clk), .rst(rst), .bus(b3));
    sr_reg_bank #(.WIDTH(W), .MODE(5), .CNT_W(CW), .RESET_VAL(RV)) u4 (.clk(clk), .rst(rst), .bus(b4));

    // Drive one cycle of stimulus at the falling edge, queue the expected post-edge state,
    // then return just after the rising edge so callers can inspect the outputs.
    task automatic step(input logic rs, input logic e, input logic [3:0] s,
                        input logic [3:0] r, input logic c);
        logic [3:0] sf, rf, both, keep;
        exp_t x;
        @(negedge clk);
        rst = rs;
        b0.en = e; b0.S = s; b0.R = r; b0.clr_err = c;
        b1.en = e; b1.S = s; b1.R = r; b1.clr_err = c;
        b2.en = e; b2.S = s; b2.R = r; b2.clr_err = c;
        b3.en = e; b3.S = s; b3.R = r; b3.clr_err = c;
        b4.en = e; b4.S = s; b4.R = r; b4.clr_err = c;
`ifdef SR_GLITCH_FILTER_EN
        sf = s & m_sd;
        rf = r & m_rd;
`else
        sf = s;
        rf = r;
`endif
        if (rs) begin
            m_q0 = RV; m_q1 = RV; m_q2 = RV; m_q3 = RV;
            m_conf = '0; m_cnt = '0; m_st = 1'b0; m_sd = '0; m_rd = '0;
        end else begin
            both = sf & rf;
            keep = ~(sf | rf);
            if (e) begin
                m_q0 = (m_q0 & keep) | (sf & ~rf);
                m_q1 = (m_q1 & keep) | (sf & ~rf) | both;
                m_q2 = (m_q2 & keep) | (sf & ~rf) | (both & ~m_q2);
                m_q3 = (m_q3 & keep) | (sf & ~rf) | (both & m_q3);
                m_conf = both;
            end else begin
                m_conf = '0;
            end
            if (c) begin
                m_cnt = '0;
                m_st  = 1'b0;
            end
            if (|m_conf) begin
                if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
                m_st = 1'b1;
            end
            m_sd = s;
            m_rd = r;
        end
        x.q0 = m_q0; x.q1 = m_q1; x.q2 = m_q2; x.q3 = m_q3;
        x.conf = m_conf; x.cnt = m_cnt; x.st = m_st;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: compare every bank against the queued expectation one edge after drive.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if (b0.Q !== e.q0) begin n_fail++; $display("FAIL sb_q_mode0: got %b want %b", b0.Q, e.q0); end
            n_checks++; if (b0.Qn !== ~e.q0) begin n_fail++; $display("FAIL sb_qn_mode0: got %b want %b", b0.Qn, ~e.q0); end
            n_checks++; if (b1.Q !== e.q1) begin n_fail++; $display("FAIL sb_q_mode1: got %b want %b", b1.Q, e.q1); end
            n_checks++; if (b2.Q !== e.q2) begin n_fail++; $display("FAIL sb_q_mode2: got %b want %b", b2.Q, e.q2); end
            n_checks++; if (b3.Q !== e.q3) begin n_fail++; $display("FAIL sb_q_mode3: got %b want %b", b3.Q, e.q3); end
            n_checks++; if (b4.Q !== e.q3) begin n_fail++; $display("FAIL sb_q_mode5: got %b want %b", b4.Q, e.q3); end
            n_checks++; if (b0.conflict !== e.conf) begin n_fail++; $display("FAIL sb_conflict: got %b want %b", b0.conflict, e.conf); end
            n_checks++; if (b0.conflict_cnt !== e.cnt) begin n_fail++; $display("FAIL sb_cnt: got %0d want %0d", b0.conflict_cnt, e.cnt); end
            n_checks++; if (b0.err_sticky !== e.st) begin n_fail++; $display("FAIL sb_sticky: got %b want %b", b0.err_sticky, e.st); end
        end
    end

    task automatic test_reset();
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'h0, 1'b1);
        n_checks++; if (b0.Q !== 4'b1010) begin n_fail++; $display("FAIL reset_q: got %b want 1010", b0.Q); end
        n_checks++; if (b0.Qn !== 4'b0101) begin n_fail++; $display("FAIL reset_qn: got %b want 0101", b0.Qn); end
        n_checks++; if (b0.conflict !== 4'b0000) begin n_fail++; $display("FAIL reset_conflict: got %b want 0000", b0.conflict); end
        n_checks++; if (b0.conflict_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", b0.err_sticky); end
    endtask

`ifndef SR_GLITCH_FILTER_EN
    task automatic test_set_reset();
        step(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
        n_checks++; if (b0.Q !== 4'b1011) begin n_fail++; $display("FAIL set_ch0: got %b want 1011", b0.Q); end
        step(1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0);
        n_checks++; if (b0.Q !== 4'b0011) begin n_fail++; $display("FAIL reset_ch3: got %b want 0011", b0.Q); end
    endtask

    task automatic test_conflict_modes();
        step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
        n_checks++; if (b0.Q !== 4'b0010) begin n_fail++; $display("FAIL mode0_conflict: got %b want 0010", b0.Q); end
        n_checks++; if (b1.Q !== 4'b0011) begin n_fail++; $display("FAIL mode1_conflict: got %b want 0011", b1.Q); end
        n_checks++; if (b2.Q !== 4'b0010) begin n_fail++; $display("FAIL mode2_conflict: got %b want 0010", b2.Q); end
        n_checks++; if (b3.Q !== 4'b0011) begin n_fail++; $display("FAIL mode3_conflict: got %b want 0011", b3.Q); end
        n_checks++; if (b4.Q !== 4'b0011) begin n_fail++; $display("FAIL mode5_conflict: got %b want 0011", b4.Q); end
        n_checks++; if (b0.conflict !== 4'b0001) begin n_fail++; $display("FAIL conflict_pulse: got %b want 0001", b0.conflict); end
        n_checks++; if (b0.conflict_cnt !== 2'd1) begin n_fail++; $display("FAIL conflict_cnt1: got %0d want 1", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky: got %b want 1", b0.err_sticky); end
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        n_checks++; if (b0.conflict !== 4'b0000) begin n_fail++; $display("FAIL conflict_one_cycle: got %b want 0000", b0.conflict); end
        step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
        n_checks++; if (b2.Q !== 4'b0011) begin n_fail++; $display("FAIL mode2_toggle_back: got %b want 0011", b2.Q); end
        n_checks++; if (b0.conflict_cnt !== 2'd2) begin n_fail++; $display("FAIL conflict_cnt2: got %0d want 2", b0.conflict_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
        n_checks++; if (b0.conflict_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b want 0", b0.err_sticky); end
        for (int i = 0; i < 6; i++) begin
            want = (i < 2) ? 2'(i + 1) : 2'd3;
            step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
            n_checks++; if (b0.conflict_cnt !== want) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, b0.conflict_cnt, want); end
            n_checks++; if (b0.conflict !== 4'hF) begin n_fail++; $display("FAIL sat_conflict[%0d]: got %b want 1111", i, b0.conflict); end
        end
    endtask

    task automatic test_enable_clear();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
            n_checks++; if (b0.Q !== 4'b0000) begin n_fail++; $display("FAIL en_low_q[%0d]: got %b want 0000", i, b0.Q); end
            n_checks++; if (b0.conflict_cnt !== 2'd3) begin n_fail++; $display("FAIL en_low_cnt[%0d]: got %0d want 3", i, b0.conflict_cnt); end
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        n_checks++; if (b0.conflict_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_en_low_cnt: got %0d want 0", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_en_low_sticky: got %b want 0", b0.err_sticky); end
        step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1);
        n_checks++; if (b0.conflict_cnt !== 2'd1) begin n_fail++; $display("FAIL clr_with_conflict_cnt: got %0d want 1", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_with_conflict_sticky: got %b want 1", b0.err_sticky); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        n_checks++; if (b0.Q !== 4'hF) begin n_fail++; $display("FAIL pre_rst_q: got %b want 1111", b0.Q); end
        n_checks++; if (b0.conflict_cnt !== 2'd3) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d want 3", b0.conflict_cnt); end
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
        n_checks++; if (b0.Q !== RV) begin n_fail++; $display("FAIL mid_rst_q: got %b want %b", b0.Q, RV); end
        n_checks++; if (b0.conflict_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", b0.conflict_cnt); end
        n_checks++; if (b0.err_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sticky: got %b want 0", b0.err_sticky); end
        n_checks++; if (b0.conflict !== 4'h0) begin n_fail++; $display("FAIL mid_rst_conflict: got %b want 0000", b0.conflict); end
    endtask
`else
    task automatic test_glitch_filter();
        step(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        n_checks++; if (b0.Q !== 4'b1010) begin n_fail++; $display("FAIL filt_pulse_ignored: got %b want 1010", b0.Q); end
        step(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0);
        n_checks++; if (b0.Q !== 4'b1010) begin n_fail++; $display("FAIL filt_first_edge: got %b want 1010", b0.Q); end
        step(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0);
        n_checks++; if (b0.Q !== 4'b1110) begin n_fail++; $display("FAIL filt_second_edge: got %b want 1110", b0.Q); end
        step(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        n_checks++; if (b0.conflict !== 4'b0000) begin n_fail++; $display("FAIL filt_no_conflict: got %b want 0000", b0.conflict); end
        n_checks++; if (b0.conflict_cnt !== 2'd0) begin n_fail++; $display("FAIL filt_cnt: got %0d want 0", b0.conflict_cnt); end
    endtask
`endif

    task automatic test_back_to_back();
        logic rs, e, c;
        logic [3:0] s, r;
        for (int i = 0; i < 60; i++) begin
            rs = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 7) == 0);
            s  = 4'($urandom);
            r  = 4'($urandom);
            step(rs, e, s, r, c);
        end
    endtask

    initial begin
        test_reset();
`ifndef SR_GLITCH_FILTER_EN
        test_set_reset();
        test_conflict_modes();
        test_saturation();
        test_enable_clear();
        test_reset_mid();
`else
        test_glitch_filter();
`endif
        test_back_to_back();
        @(negedge clk);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d entries left, want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
